kbd_instr_issuer: RTL and testbench

Keypad-side instruction issuer for the calculator datapath. Accepts decoded key events, queues them in a small FIFO, maps each key to a 3-bit controller instruction, and drives the `new_instruction`/`instruction` pair into the controller FSM. It paces issue on the controller's `ready` output: one instruction in flight at a time, with a bounded wait.

---
 rtl/kbd_instr_issuer.sv | 187 ++++++++++++++++++
 tb/tb_kbd_instr_issuer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_instr_issuer.sv
// Keypad instruction issuer: queues decoded key events and hands them to the
// controller FSM one at a time, pacing on the controller's ready handshake.
module kbd_instr_issuer #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       ready,
  output logic       new_instruction,
  output logic [2:0] instruction,
  output logic [3:0] digit,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow,
  output logic       timeout_err
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned PW      = AW + 1;
  localparam int unsigned EW      = 7;
  localparam int unsigned CNT_MAX = (TIMEOUT > HOLD_CYCLES) ? TIMEOUT : HOLD_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [2:0] I_CLRLD = 3'b000;
  localparam logic [2:0] I_ADD   = 3'b001;
  localparam logic [2:0] I_SUB   = 3'b010;
  localparam logic [2:0] I_DISP  = 3'b011;
  localparam logic [2:0] I_LOAD  = 3'b100;
  localparam logic [2:0] I_IDLE  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_RELEASE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic            fifo_full_q, fifo_full_d;
  logic            overflow_q, overflow_d;
  logic            timeout_err_q, timeout_err_d;
  logic            new_instruction_q, new_instruction_d;
  logic [2:0]      instruction_q, instruction_d;
  logic [3:0]      digit_q, digit_d;
  logic            busy_q, busy_d;

  logic            key_ok;
  logic [2:0]      key_instr;
  logic [3:0]      key_digit;
  logic            push_req, push, pop, empty;
  logic [EW-1:0]   head;

  // Key decode at push time; 0xE/0xF never reach the queue.
  always_comb begin
    key_ok    = 1'b1;
    key_instr = I_LOAD;
    key_digit = 4'd0;
    case (key_code)
      4'hA:        key_instr = I_ADD;
      4'hB:        key_instr = I_SUB;
      4'hC:        key_instr = I_CLRLD;
      4'hD:        key_instr = I_DISP;
      4'hE, 4'hF: begin
        key_ok    = 1'b0;
        key_instr = I_IDLE;
      end
      default:     key_digit = key_code;
    endcase
  end

  // Queue bookkeeping; a push against a full queue is dropped even if a pop frees a slot.
  always_comb begin
    empty       = (wr_ptr_q == rd_ptr_q);
    push_req    = key_valid && key_ok;
    push        = push_req && !fifo_full_q;
    head        = mem_q[rd_ptr_q[AW-1:0]];
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    fifo_full_d = (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    overflow_d  = overflow_q | (push_req & fifo_full_q);
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q[AW-1:0]] <= {key_instr, key_digit};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state, wait counter and pop decision
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pop           = 1'b0;
    timeout_err_d = timeout_err_q;
    case (state_q)
      S_IDLE: begin
        if (!empty && ready) begin
          pop     = 1'b1;
          cnt_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!ready) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          cnt_d         = '0;
          timeout_err_d = 1'b1;
          state_d       = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RELEASE: begin
        if (ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the next cycle: load head on pop, hold through ISSUE/HOLD.
  always_comb begin
    new_instruction_d = 1'b0;
    instruction_d     = I_IDLE;
    digit_d           = 4'd0;
    busy_d            = (state_d != S_IDLE);
    if (pop) begin
      new_instruction_d          = 1'b1;
      {instruction_d, digit_d}   = head;
    end else if (state_d == S_ISSUE || state_d == S_HOLD) begin
      new_instruction_d = new_instruction_q;
      instruction_d     = instruction_q;
      digit_d           = digit_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q             <= '0;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      fifo_full_q       <= 1'b0;
      overflow_q        <= 1'b0;
      timeout_err_q     <= 1'b0;
      new_instruction_q <= 1'b0;
      instruction_q     <= I_IDLE;
      digit_q           <= 4'd0;
      busy_q            <= 1'b0;
    end else begin
      cnt_q             <= cnt_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      fifo_full_q       <= fifo_full_d;
      overflow_q        <= overflow_d;
      timeout_err_q     <= timeout_err_d;
      new_instruction_q <= new_instruction_d;
      instruction_q     <= instruction_d;
      digit_q           <= digit_d;
      busy_q            <= busy_d;
    end
  end

  assign new_instruction = new_instruction_q;
  assign instruction     = instruction_q;
  assign digit           = digit_q;
  assign busy            = busy_q;
  assign fifo_full       = fifo_full_q;
  assign overflow        = overflow_q;
  assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_kbd_instr_issuer.sv
// Bench for kbd_instr_issuer: directed key sequences against a registered
// controller model, with a scoreboard of expected issued instructions.
module tb_kbd_instr_issuer;

  localparam int unsigned HOLD = 2;
  localparam int unsigned TMO  = 15;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code  = 4'd0;
  logic       ready;
  logic       new_instruction;
  logic [2:0] instruction;
  logic [3:0] digit;
  logic       busy;
  logic       fifo_full;
  logic       overflow;
  logic       timeout_err;

  int         checks    = 0;
  int         errors    = 0;
  int         n_issued  = 0;
  int         hi_len    = 0;
  int         last_len  = 0;
  logic       prev_ni   = 1'b0;
  logic       check_len = 1'b1;
  logic [6:0] sb [$];
  logic [6:0] mon_e;

  logic       ctrl_mode  = 1'b0;
  logic       ctrl_level = 1'b1;
  logic       c_busy;
  logic [1:0] c_rel;

  kbd_instr_issuer #(
    .FIFO_DEPTH (4),
    .HOLD_CYCLES(HOLD),
    .TIMEOUT    (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .ready          (ready),
    .new_instruction(new_instruction),
    .instruction    (instruction),
    .digit          (digit),
    .busy           (busy),
    .fifo_full      (fifo_full),
    .overflow       (overflow),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_entry(input logic [3:0] c);
    case (c)
      4'hA:    return {3'b001, 4'd0};
      4'hB:    return {3'b010, 4'd0};
      4'hC:    return {3'b000, 4'd0};
      4'hD:    return {3'b011, 4'd0};
      default: return {3'b100, c};
    endcase
  endfunction

  // Controller model: ready drops one edge after it sees new_instruction,
  // returns two edges after new_instruction is released.
  always @(posedge clk) begin
    if (rst) begin
      ready  <= 1'b0;
      c_busy <= 1'b0;
      c_rel  <= 2'd0;
    end else if (ctrl_mode) begin
      ready  <= ctrl_level;
      c_busy <= 1'b0;
      c_rel  <= 2'd0;
    end else if (!c_busy) begin
      if (new_instruction) begin
        ready  <= 1'b0;
        c_busy <= 1'b1;
      end else begin
        ready <= 1'b1;
      end
    end else if (!new_instruction) begin
      if (c_rel == 2'd1) begin
        ready  <= 1'b1;
        c_busy <= 1'b0;
        c_rel  <= 2'd0;
      end else begin
        c_rel <= c_rel + 2'd1;
      end
    end
  end

  // Issue monitor: scoreboard pop on each rising new_instruction
  always @(negedge clk) begin
    if (new_instruction && !prev_ni) begin
      n_issued++;
      hi_len = 1;
      check("issue_ready", 32'(ready), 32'd1);
      check("issue_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("issue_instr", 32'(instruction), 32'(mon_e[6:4]));
        check("issue_digit", 32'(digit), 32'(mon_e[3:0]));
      end
    end else if (new_instruction) begin
      hi_len++;
    end else if (prev_ni) begin
      last_len = hi_len;
      if (check_len) check("hold_len", 32'(hi_len), 32'(2 + HOLD));
    end
    prev_ni = new_instruction;
  end

  task automatic push_key(input logic [3:0] code, input bit expect_push);
    key_valid = 1'b1;
    key_code  = code;
    if (expect_push) sb.push_back(exp_entry(code));
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic wait_quiet(input string tag);
    int idle = 0;
    int t    = 0;
    while (idle < 4 && t < 400) begin
      @(negedge clk);
      t++;
      if (!busy && !new_instruction && sb.size() == 0) idle++;
      else idle = 0;
    end
    check(tag, 32'(idle >= 4), 32'd1);
  endtask

  initial begin
    int base;
    int t;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_new",     32'(new_instruction), 32'd0);
    check("rst_instr",   32'(instruction),     32'h5);
    check("rst_digit",   32'(digit),           32'd0);
    check("rst_busy",    32'(busy),            32'd0);
    check("rst_full",    32'(fifo_full),       32'd0);
    check("rst_ovf",     32'(overflow),        32'd0);
    check("rst_tmo",     32'(timeout_err),     32'd0);
    repeat (2) @(negedge clk);

    // Single key with two-cycle issue latency
    push_key(4'h7, 1'b1);
    check("lat_n",  32'(new_instruction), 32'd0);
    @(negedge clk);
    check("lat_n1", 32'(new_instruction), 32'd1);
    wait_quiet("single_done");
    check("single_instr", 32'(instruction), 32'h5);
    check("single_digit", 32'(digit),       32'd0);
    check("single_busy",  32'(busy),        32'd0);
    check("single_len",   32'(last_len),    32'(2 + HOLD));

    // Back-to-back keys issue in order
    base = n_issued;
    push_key(4'h3, 1'b1);
    push_key(4'hA, 1'b1);
    push_key(4'h5, 1'b1);
    push_key(4'hD, 1'b1);
    wait_quiet("seq_done");
    check("seq_count", 32'(n_issued), 32'(base + 4));

    // Unused keys are discarded silently
    base = n_issued;
    push_key(4'hE, 1'b0);
    push_key(4'hF, 1'b0);
    repeat (6) @(negedge clk);
    check("unused_issue", 32'(n_issued),  32'(base));
    check("unused_ovf",   32'(overflow),  32'd0);
    check("unused_full",  32'(fifo_full), 32'd0);
    check("unused_busy",  32'(busy),      32'd0);

    // Overflow with ready held low
    base       = n_issued;
    ctrl_level = 1'b0;
    ctrl_mode  = 1'b1;
    repeat (3) @(negedge clk);
    push_key(4'h1, 1'b1);
    push_key(4'h2, 1'b1);
    push_key(4'h3, 1'b1);
    check("ovf_not_full3", 32'(fifo_full), 32'd0);
    push_key(4'hB, 1'b1);
    check("ovf_full4", 32'(fifo_full), 32'd1);
    check("ovf_ovf4",  32'(overflow),  32'd0);
    push_key(4'h4, 1'b0);
    check("ovf_ovf5",  32'(overflow),  32'd1);
    check("ovf_full5", 32'(fifo_full), 32'd1);
    check("ovf_noissue", 32'(n_issued), 32'(base));
    check("ovf_busy",    32'(busy),     32'd0);
    ctrl_mode = 1'b0;
    wait_quiet("ovf_drain");
    check("ovf_count",  32'(n_issued),  32'(base + 4));
    check("ovf_empty",  32'(fifo_full), 32'd0);
    check("ovf_sticky", 32'(overflow),  32'd1);

    // Timeout with ready stuck high, next entry issues normally
    base       = n_issued;
    check_len  = 1'b0;
    ctrl_level = 1'b1;
    ctrl_mode  = 1'b1;
    push_key(4'hC, 1'b1);
    push_key(4'h9, 1'b1);
    t = 0;
    while (!new_instruction && t < 20) begin
      @(negedge clk);
      t++;
    end
    while (new_instruction && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("tmo_seen", 32'(t < 60), 32'd1);
    @(negedge clk);
    check("tmo_len", 32'(last_len),    32'(TMO));
    check("tmo_err", 32'(timeout_err), 32'd1);
    check_len = 1'b1;
    ctrl_mode = 1'b0;
    wait_quiet("tmo_next");
    check("tmo_count",  32'(n_issued),    32'(base + 2));
    check("tmo_sticky", 32'(timeout_err), 32'd1);

    // Reset during HOLD discards the queue
    base      = n_issued;
    check_len = 1'b0;
    push_key(4'h6, 1'b1);
    push_key(4'h7, 1'b1);
    push_key(4'h8, 1'b1);
    @(negedge clk);
    check("hold_pre_rst", 32'(new_instruction), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_new",   32'(new_instruction), 32'd0);
    check("mrst_instr", 32'(instruction),     32'h5);
    check("mrst_digit", 32'(digit),           32'd0);
    check("mrst_busy",  32'(busy),            32'd0);
    check("mrst_full",  32'(fifo_full),       32'd0);
    check("mrst_ovf",   32'(overflow),        32'd0);
    check("mrst_tmo",   32'(timeout_err),     32'd0);
    rst = 1'b0;
    sb.delete();
    repeat (30) @(negedge clk);
    check("mrst_noissue", 32'(n_issued),        32'(base + 1));
    check("mrst_idle",    32'(busy),            32'd0);
    check("mrst_new2",    32'(new_instruction), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
